// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, timing defaults and refresh FSM states
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;

  localparam int CNT_REF_MAX_DEF = 750;
  localparam int TRP_CLK_DEF     = 2;
  localparam int TRC_CLK_DEF     = 7;

  localparam logic [12:0] ADDR_ALL_BANKS = 13'h0400;
  localparam logic [12:0] ADDR_IDLE      = 13'h1FFF;
  localparam logic [1:0]  BANK_IDLE      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PCHG,
    ST_TRP,
    ST_AREF,
    ST_TRF,
    ST_END
  } aref_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - free-running refresh interval counter and sticky request flag
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int CNT_REF_MAX = CNT_REF_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_end,
  input  logic grant_acc,
  output logic aref_req
);

  localparam int            CW       = cnt_width(CNT_REF_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_REF_MAX - 1);

  logic [CW-1:0] cnt_ref_q, cnt_ref_d;
  logic          req_q, req_d;
  logic          wrap;

  // A grant on the wrap edge consumes that wrap; no request is queued.
  always_comb begin
    wrap      = init_end && (cnt_ref_q == CNT_LAST);
    cnt_ref_d = '0;
    if (init_end && !wrap) cnt_ref_d = cnt_ref_q + CW'(1);
    req_d = req_q;
    if (grant_acc)  req_d = 1'b0;
    else if (wrap)  req_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ref_q <= '0;
      req_q     <= 1'b0;
    end else begin
      cnt_ref_q <= cnt_ref_d;
      req_q     <= req_d;
    end
  end

  assign aref_req = req_q;

endmodule

// File: rtl/sdram_aref.sv
// rtl/sdram_aref.sv - auto-refresh generator: PRECHARGE-ALL then N AUTO REFRESH per grant
// SDRAM_AREF_DOUBLE_EN defined: two AUTO REFRESH commands per grant, otherwise one.
module sdram_aref
  import sdram_pkg::*;
#(
  parameter int CNT_REF_MAX = CNT_REF_MAX_DEF,
  parameter int TRP_CLK     = TRP_CLK_DEF,
  parameter int TRC_CLK     = TRC_CLK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_bank_addr,
  output logic [12:0] aref_addr,
  output logic        aref_end
);

`ifdef SDRAM_AREF_DOUBLE_EN
  localparam logic [1:0] REF_LAST = 2'd2;
`else
  localparam logic [1:0] REF_LAST = 2'd1;
`endif

  // Wait states last one cycle less than the interval, the command cycle counts too.
  localparam logic [7:0] TRP_LAST = 8'(TRP_CLK - 2);
  localparam logic [7:0] TRC_LAST = 8'(TRC_CLK - 2);

  aref_state_e state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  ref_q, ref_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic        end_q, end_d;
  logic        grant_acc;

  assign grant_acc = (state_q == ST_IDLE) && aref_req && aref_en;

  sdram_ref_timer #(
    .CNT_REF_MAX(CNT_REF_MAX)
  ) u_ref_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_end (init_end),
    .grant_acc(grant_acc),
    .aref_req (aref_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      ref_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= ADDR_IDLE;
      bank_q  <= BANK_IDLE;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_acc) state_d = ST_PCHG;
      ST_PCHG: state_d = ST_TRP;
      ST_TRP:  if (wait_q == TRP_LAST) state_d = ST_AREF;
      ST_AREF: state_d = ST_TRF;
      ST_TRF:  if (wait_q == TRC_LAST) state_d = (ref_q == REF_LAST) ? ST_END : ST_AREF;
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    wait_d = '0;
    if ((state_q == ST_TRP || state_q == ST_TRF) && state_d == state_q)
      wait_d = wait_q + 8'd1;

    case (state_q)
      ST_IDLE: ref_d = '0;
      ST_AREF: ref_d = ref_q + 2'd1;
      default: ref_d = ref_q;
    endcase
  end

  // Decoded from the next state so the registered bus lines up with the state itself.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = ADDR_IDLE;
    bank_d = BANK_IDLE;
    end_d  = 1'b0;
    case (state_d)
      ST_PCHG: begin
        cmd_d  = CMD_PRECHARGE;
        addr_d = ADDR_ALL_BANKS;
      end
      ST_AREF: cmd_d = CMD_AREF;
      ST_END:  end_d = 1'b1;
      default: ;
    endcase
  end

  assign aref_cmd       = cmd_q;
  assign aref_addr      = addr_q;
  assign aref_bank_addr = bank_q;
  assign aref_end       = end_q;

endmodule

// File: tb/tb_sdram_aref.sv
// tb/tb_sdram_aref.sv - self-checking bench for sdram_aref with a timeline-based reference model
module tb_sdram_aref;
  import sdram_pkg::*;

  localparam int MAX = 750;
  localparam int TRP = 2;
  localparam int TRC = 7;
`ifdef SDRAM_AREF_DOUBLE_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif
  localparam int END_OFF = 1 + TRP + N * TRC;

  logic        clk = 1'b0;
  logic        rst_n, init_end, aref_en;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_bank_addr;
  logic [12:0] aref_addr;

  always #5 clk = ~clk;

  sdram_aref #(
    .CNT_REF_MAX(MAX),
    .TRP_CLK    (TRP),
    .TRC_CLK    (TRC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_end      (init_end),
    .aref_en       (aref_en),
    .aref_req      (aref_req),
    .aref_cmd      (aref_cmd),
    .aref_bank_addr(aref_bank_addr),
    .aref_addr     (aref_addr),
    .aref_end      (aref_end)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: requests come every MAX sampled init_end edges; a grant fixes the sequence timeline.
  int edge_n = 0;
  int run_len = 0;
  int m_t = 0;
  bit m_req = 0, m_seq = 0, m_idle, m_wrap, m_grant;

  always @(posedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      m_req   = 0;
      m_seq   = 0;
    end else begin
      m_idle  = !m_seq || (edge_n - m_t > END_OFF);
      m_grant = m_idle && m_req && aref_en;
      m_wrap  = 0;
      if (init_end) begin
        run_len++;
        m_wrap = (run_len % MAX) == 0;
      end else begin
        run_len = 0;
      end
      if (m_grant) begin
        m_req = 0;
        m_seq = 1;
        m_t   = edge_n;
      end else if (m_wrap) begin
        m_req = 1;
      end
    end
    edge_n++;
  end

  function automatic logic [3:0] exp_cmd(input int o, input bit seq);
    if (!seq) return CMD_NOP;
    if (o == 1) return CMD_PRECHARGE;
    if (o >= 1 + TRP && o < END_OFF && ((o - 1 - TRP) % TRC) == 0) return CMD_AREF;
    return CMD_NOP;
  endfunction

  int o;
  int req_rise = -1, pchg_e = -1, aref1_e = -1, aref2_e = -1, end_e = -1;
  int pchg_cnt = 0, aref_since = 0;
  bit req_prev = 0;

  always @(negedge clk) begin
    o = edge_n - m_t;
    check("cmd",  aref_cmd, exp_cmd(o, m_seq));
    check("addr", aref_addr, (m_seq && o == 1) ? 13'h0400 : 13'h1FFF);
    check("bank", aref_bank_addr, 2'b11);
    check("req",  aref_req, m_req);
    check("end",  aref_end, m_seq && o == END_OFF);
    if (aref_req && !req_prev) req_rise = edge_n - 1;
    req_prev = aref_req;
    if (aref_cmd == CMD_PRECHARGE) begin
      pchg_e = edge_n - 1;
      pchg_cnt++;
      aref_since = 0;
    end
    if (aref_cmd == CMD_AREF) begin
      if (aref_since == 0) aref1_e = edge_n - 1;
      else aref2_e = edge_n - 1;
      aref_since++;
    end
    if (aref_end) end_e = edge_n - 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int s, t, p0, r0;

  initial begin
    rst_n = 0; init_end = 0; aref_en = 0;
    step(3);
    check("rst_cmd",  aref_cmd, 4'b0111);
    check("rst_addr", aref_addr, 13'h1FFF);
    check("rst_bank", aref_bank_addr, 2'b11);
    check("rst_req",  aref_req, 0);
    check("rst_end",  aref_end, 0);
    rst_n = 1;
    step(5);

    init_end = 1;
    s = edge_n;
    step(100);
    aref_en = 1;
    step(1);
    aref_en = 0;
    step(800);
    check("first_req_latency", req_rise - s, 749);
    step(400);
    check("req_held", aref_req, 1);
    check("no_seq_without_grant", pchg_cnt, 0);

    aref_en = 1;
    t = edge_n;
    step(1);
    aref_en = 0;
    check("req_fall", aref_req, 0);
    step(4);
    aref_en = 1;
    step(1);
    aref_en = 0;
    step(20);
    check("pchg_offset", pchg_e - t, 0);
    check("aref1_offset", aref1_e - t, 2);
`ifdef SDRAM_AREF_DOUBLE_EN
    check("aref2_offset", aref2_e - t, 9);
    check("end_offset", end_e - t, 16);
`else
    check("end_offset", end_e - t, 9);
`endif

    p0 = pchg_cnt;
    step(2000);
    check("withhold_no_seq", pchg_cnt - p0, 0);
    check("withhold_req", aref_req, 1);
    for (int i = 0; i < MAX && (run_len % MAX) != MAX - 1; i++) step(1);
    aref_en = 1;
    t = edge_n;
    p0 = pchg_cnt;
    step(1);
    check("same_edge_wrap_consumed", aref_req, 0);
    step(1600);
    check("seq_count_held_grant", pchg_cnt - p0, 3);
    check("third_pchg_offset", pchg_e - t, 1501);

    p0 = pchg_cnt;
    for (int i = 0; i < 800 && pchg_cnt == p0; i++) step(1);
    check("pchg_seen_a", pchg_cnt != p0, 1);
    step(3);
    init_end = 0;
    step(10);
    init_end = 1;
    step(30);

    p0 = pchg_cnt;
    for (int i = 0; i < 800 && pchg_cnt == p0; i++) step(1);
    check("pchg_seen_b", pchg_cnt != p0, 1);
    step(4);
    #1;
    rst_n = 0;
    #1;
    check("async_rst_cmd",  aref_cmd, 4'b0111);
    check("async_rst_addr", aref_addr, 13'h1FFF);
    check("async_rst_bank", aref_bank_addr, 2'b11);
    check("async_rst_req",  aref_req, 0);
    check("async_rst_end",  aref_end, 0);
    aref_en = 0;
    step(2);
    rst_n = 1;
    s = edge_n;
    r0 = req_rise;
    for (int i = 0; i < 800 && req_rise == r0; i++) step(1);
    check("req_after_reset", req_rise - s, 749);
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
